accel_bus_initiator: RTL and testbench
======================================

# accel_bus_initiator

Bus initiator that drives the TinyQV-style peripheral register port (address / data_write / data_in / data_out) of the configurable accelerator from a byte-wide valid/ready command stream. It lets a non-CPU source, such as a UART byte decoder or a test sequencer, program operand registers, select the ALU opcode, and read results. It sits between the command source and the accelerator's register port, and returns read data on a separate valid/ready response stream.

## Interface
- READ_WAIT, default 1: cycles between driving a read address and sampling bus_rdata (legal range 1-7).
- clk  in  1  project clock (64 MHz nominal).
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command byte valid.
- cmd_ready  out  1  command byte accepted when cmd_valid && cmd_ready.
- cmd_data  in  8  command byte (header or write data).
- rsp_valid  out  1  read data valid; held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  8  read data.
- bus_address  out  4  register address to the peripheral.
- bus_data_write  out  1  single-cycle write strobe.
- bus_wdata  out  8  write data, valid while bus_data_write is high.
- bus_rdata  in  8  peripheral data_out; combinational function of bus_address.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Header byte layout:
  - [7] selects read (1) or write (0).
  - [6] enables auto-increment of the address.
  - [5:4] is beat count minus 1, giving 1-4 beats.
  - [3:0] is the start address.
- A write header is followed by one data byte per beat. A read header returns one rsp beat per beat.
- States:
  - IDLE: cmd_ready=1. Accepting a header latches addr, beats and inc, then goes to WDATA (write) or RWAIT (read).
  - WDATA: cmd_ready=1. Accepting a byte latches it into bus_wdata and goes to WRITE.
  - WRITE: bus_data_write=1 for exactly this cycle; cmd_ready=0. If this was the last beat, go to IDLE. Otherwise advance the address (if inc) and go to WDATA.
  - RWAIT: counts READ_WAIT cycles with bus_address stable, samples bus_rdata into rsp_data on the final cycle, then goes to RESP.
  - RESP: rsp_valid=1 until rsp_ready. On the handshake, go to IDLE if this was the last beat. Otherwise advance the address (if inc) and go to RWAIT.
- Address arithmetic is 4-bit with wrap: 4'hF + 1 = 4'h0. With inc=0, every beat targets the same address.
- Header bits are decoded only in IDLE. A byte accepted in WDATA is always treated as data, even if bit 7 is set.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, bus_address 0, bus_data_write 0, bus_wdata 0, busy 0.
- Reset asserted mid-transaction aborts it immediately. No partial write strobe is emitted and any pending response is dropped.

## Timing
- bus_address, bus_wdata, bus_data_write, rsp_data and rsp_valid are all registered outputs.
- cmd_ready and busy are decoded from state, with no combinational path from cmd_valid or rsp_ready.
- Write, header accepted at cycle N: bus_address is valid from N+1. A data byte accepted at cycle M produces bus_data_write in cycle M+1 only. Peak rate is one write per 2 cycles.
- Read, header accepted at cycle N: bus_address is valid from N+1, bus_rdata is sampled at the end of cycle N+READ_WAIT, and rsp_valid rises at N+READ_WAIT+1.
- bus_address never changes while rsp_valid=1 or bus_data_write=1.
- rsp_valid held under backpressure: rsp_data stays stable and no new bus read is issued.
- A cmd_valid arriving while in WRITE, RWAIT or RESP is simply not accepted; no bytes are lost.

## Structure
- Package accel_bus_pkg holds:
  - the state enum (IDLE, WDATA, WRITE, RWAIT, RESP);
  - header field constants HDR_RD_BIT=7, HDR_INC_BIT=6, HDR_LEN_MSB=5, HDR_LEN_LSB=4;
  - the accelerator register map constants ADDR_A=0, ADDR_B=1, ADDR_C=2, ADDR_D=3, ADDR_OP=4, ADDR_RES=5.
- Single module with no sub-module. The beat counter and wait counter are local registers.
- The test bench instantiates the accelerator as the bus responder.

## Test plan
- Single writes: write 0x05 to 0x0, 0x03 to 0x1, 0x00 to 0x4, then a single read of 0x5 -> rsp_data=0x08. Each write strobe lasts exactly 1 cycle, one cycle after its data byte is accepted.
- Subtract path: write 0x01 to 0x4, with A=0x03 and B=0x05, then read 0x5 -> rsp_data=0xFE (8-bit wrap).
- Burst with wrap: write header 0x7F followed by data 0x11 0x22 0x33 0x44 -> strobes at addresses 0xF, 0x0, 0x1, 0x2. A burst read header 0xF0 then returns 0x22 0x33 0x44 0x00 (read 0x3 = D = 0).
- Backpressure: read 0x0 with rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, bus_address constant. One handshake returns the state to IDLE.
- READ_WAIT=3: read 0x1 -> rsp_valid rises exactly 4 cycles after the header handshake.
- Reset mid-burst: assert rst_n low while in WDATA after 2 of 4 beats -> all outputs take their reset values asynchronously. After release, a fresh single write to 0x2 completes and 0x3 is unchanged.

Source files
------------

// File: rtl/accel_bus_pkg.sv
// Shared types and constants for the accelerator bus initiator: FSM states,
// command header field positions and the accelerator register map.
package accel_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRITE = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam int HDR_RD_BIT  = 7;
    localparam int HDR_INC_BIT = 6;
    localparam int HDR_LEN_MSB = 5;
    localparam int HDR_LEN_LSB = 4;

    localparam logic [3:0] ADDR_A   = 4'h0;
    localparam logic [3:0] ADDR_B   = 4'h1;
    localparam logic [3:0] ADDR_C   = 4'h2;
    localparam logic [3:0] ADDR_D   = 4'h3;
    localparam logic [3:0] ADDR_OP  = 4'h4;
    localparam logic [3:0] ADDR_RES = 4'h5;

    // 4-bit address step; wraps 0xF -> 0x0 naturally.
    function automatic logic [3:0] next_addr(input logic [3:0] addr, input logic inc);
        return inc ? addr + 4'd1 : addr;
    endfunction

endpackage

// File: rtl/accel_bus_initiator.sv
// Converts a byte-wide header/data command stream into register-port writes and
// reads on the accelerator, returning read data on a valid/ready response stream.
module accel_bus_initiator
    import accel_bus_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] bus_address,
    output logic       bus_data_write,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [1:0] beats_q, beats_d;
    logic       inc_q, inc_d;
    logic [2:0] wait_q, wait_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_q, wr_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 4'h0;
            beats_q     <= 2'd0;
            inc_q       <= 1'b0;
            wait_q      <= 3'd0;
            wdata_q     <= 8'h00;
            wr_q        <= 1'b0;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            inc_q       <= inc_d;
            wait_q      <= wait_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        inc_d       = inc_q;
        wait_d      = wait_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_data[3:0];
                    beats_d = cmd_data[HDR_LEN_MSB:HDR_LEN_LSB];
                    inc_d   = cmd_data[HDR_INC_BIT];
                    if (cmd_data[HDR_RD_BIT]) begin
                        wait_d  = WAIT_LOAD;
                        state_d = RWAIT;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                // Any byte here is payload, whatever its top bit says.
                if (cmd_valid) begin
                    wdata_d = cmd_data;
                    wr_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (beats_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    beats_d = beats_q - 2'd1;
                    addr_d  = next_addr(addr_q, inc_q);
                    state_d = WDATA;
                end
            end
            RWAIT: begin
                if (wait_q == 3'd0) begin
                    rdata_d     = bus_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP: begin
                // Address only moves on the handshake, so it is frozen under backpressure.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (beats_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d = beats_q - 2'd1;
                        addr_d  = next_addr(addr_q, inc_q);
                        wait_d  = WAIT_LOAD;
                        state_d = RWAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready      = (state_q == IDLE) || (state_q == WDATA);
    assign busy           = (state_q != IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rdata_q;
    assign bus_address    = addr_q;
    assign bus_data_write = wr_q;
    assign bus_wdata      = wdata_q;

endmodule

// File: tb/tb_accel_bus_initiator.sv
// Directed bench for accel_bus_initiator with a behavioural accelerator as the
// bus responder; a second instance runs with READ_WAIT=3 for latency checks.
module tb_accel_bus_initiator;
    import accel_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, bus_data_write, busy;
    logic [7:0] cmd_data, rsp_data, bus_wdata, bus_rdata;
    logic [3:0] bus_address;

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, bus_data_write3, busy3;
    logic [7:0] cmd_data3, rsp_data3, bus_wdata3, bus_rdata3;
    logic [3:0] bus_address3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    accel_bus_initiator #(.READ_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bus_address(bus_address), .bus_data_write(bus_data_write),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    accel_bus_initiator #(.READ_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .bus_address(bus_address3), .bus_data_write(bus_data_write3),
        .bus_wdata(bus_wdata3), .bus_rdata(bus_rdata3), .busy(busy3)
    );

    // Behavioural accelerator: operand registers, opcode, combinational result.
    logic [7:0] acc_a = 8'h00, acc_b = 8'h00, acc_c = 8'h00, acc_d = 8'h00, acc_op = 8'h00;

    always @(posedge clk) begin
        if (bus_data_write) begin
            case (bus_address)
                ADDR_A:  acc_a  <= bus_wdata;
                ADDR_B:  acc_b  <= bus_wdata;
                ADDR_C:  acc_c  <= bus_wdata;
                ADDR_D:  acc_d  <= bus_wdata;
                ADDR_OP: acc_op <= bus_wdata;
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] acc_read(input logic [3:0] a);
        case (a)
            ADDR_A:   return acc_a;
            ADDR_B:   return acc_b;
            ADDR_C:   return acc_c;
            ADDR_D:   return acc_d;
            ADDR_OP:  return acc_op;
            ADDR_RES: return (acc_op == 8'h00) ? acc_a + acc_b :
                             (acc_op == 8'h01) ? acc_a - acc_b : acc_a & acc_b;
            default:  return 8'h00;
        endcase
    endfunction

    assign bus_rdata  = acc_read(bus_address);
    assign bus_rdata3 = acc_read(bus_address3);

    typedef struct {
        logic [7:0]  hdr;
        int          n;
        logic [31:0] dat;  // beat i in bits [8i+7:8i]: write data or expected read data
        logic [15:0] adr;  // beat i address in bits [4i+3:4i]
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && g < 50) begin
            step();
            g++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [7:0] exp_d, input logic [3:0] exp_a);
        int g;
        g = 0;
        while (!rsp_valid && g < 20) begin
            step();
            g++;
        end
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
        chk("rd_addr", {28'd0, bus_address}, {28'd0, exp_a});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        send_byte(v.hdr);
        chk("hdr_addr", {28'd0, bus_address}, {28'd0, v.adr[3:0]});
        for (int b = 0; b < v.n; b++) begin
            if (v.hdr[7]) begin
                get_rsp(v.dat[8*b +: 8], v.adr[4*b +: 4]);
            end else begin
                send_byte(v.dat[8*b +: 8]);
                chk("wr_strobe", {31'd0, bus_data_write}, 32'd1);
                chk("wr_addr", {28'd0, bus_address}, {28'd0, v.adr[4*b +: 4]});
                chk("wr_data", {24'd0, bus_wdata}, {24'd0, v.dat[8*b +: 8]});
                step();
                chk("wr_strobe_end", {31'd0, bus_data_write}, 32'd0);
            end
        end
        chk("idle_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"},  {24'd0, rsp_data}, 32'd0);
        chk({tag, "_addr"},      {28'd0, bus_address}, 32'd0);
        chk({tag, "_wr"},        {31'd0, bus_data_write}, 32'd0);
        chk({tag, "_wdata"},     {24'd0, bus_wdata}, 32'd0);
        chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        vecs[0]  = '{8'h00, 1, 32'h0000_0005, 16'h0000};
        vecs[1]  = '{8'h01, 1, 32'h0000_0003, 16'h0001};
        vecs[2]  = '{8'h04, 1, 32'h0000_0000, 16'h0004};
        vecs[3]  = '{8'h85, 1, 32'h0000_0008, 16'h0005};
        vecs[4]  = '{8'h04, 1, 32'h0000_0001, 16'h0004};
        vecs[5]  = '{8'h00, 1, 32'h0000_0003, 16'h0000};
        vecs[6]  = '{8'h01, 1, 32'h0000_0005, 16'h0001};
        vecs[7]  = '{8'h85, 1, 32'h0000_00FE, 16'h0005};
        vecs[8]  = '{8'h7F, 4, 32'h4433_2211, 16'h210F};
        vecs[9]  = '{8'hF0, 4, 32'h0044_3322, 16'h3210};
        vecs[10] = '{8'h13, 2, 32'h0000_85AA, 16'h0033};
        vecs[11] = '{8'h93, 2, 32'h0000_8585, 16'h0033};

        rst_n = 1'b0;
        cmd_valid = 1'b0;  cmd_data = 8'h00;  rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; cmd_data3 = 8'h00; rsp_ready3 = 1'b0;
        step();
        step();
        chk_reset_outputs("por");
        chk("por3_wr", {31'd0, bus_data_write3}, 32'd0);
        chk("por3_wdata", {24'd0, bus_wdata3}, 32'd0);
        chk("por3_busy", {31'd0, busy3}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < NV; v++) run_vec(vecs[v]);

        // Backpressure on a read of A (0x22 after the wrapping burst).
        send_byte(8'h80);
        chk("bp_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("bp_rsp_rise", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", {24'd0, rsp_data}, 32'h22);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_addr", {28'd0, bus_address}, 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle", {31'd0, busy}, 32'd0);
        chk("bp_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);

        // READ_WAIT=3 latency: rsp_valid exactly 4 cycles after the header edge.
        chk("rw3_ready", {31'd0, cmd_ready3}, 32'd1);
        cmd_valid3 = 1'b1;
        cmd_data3  = 8'h81;
        step();
        cmd_valid3 = 1'b0;
        chk("rw3_addr", {28'd0, bus_address3}, 32'h1);
        cnt = 1;
        while (!rsp_valid3 && cnt < 12) begin
            step();
            cnt++;
        end
        chk("rw3_latency", cnt, 4);
        chk("rw3_data", {24'd0, rsp_data3}, 32'h33);
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
        chk("rw3_idle", {31'd0, busy3}, 32'd0);

        // Reset in WDATA after 2 of 4 non-incrementing beats to address 0x2.
        send_byte(8'h32);
        for (int b = 0; b < 2; b++) begin
            send_byte(8'h5A + 8'(b));
            chk("mid_wr_strobe", {31'd0, bus_data_write}, 32'd1);
            step();
        end
        chk("mid_in_wdata", {31'd0, busy & cmd_ready}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async_rst");
        step();
        chk("rst_no_strobe", {31'd0, bus_data_write}, 32'd0);
        rst_n = 1'b1;
        step();
        run_vec('{8'h82, 1, 32'h0000_005B, 16'h0002});
        run_vec('{8'h02, 1, 32'h0000_0077, 16'h0002});
        run_vec('{8'h82, 1, 32'h0000_0077, 16'h0002});
        run_vec('{8'h83, 1, 32'h0000_0085, 16'h0003});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
